// File: rtl/gray_decode_monitor.sv
// Gray-code stream consumer: registers the binary decode of each accepted code,
// flags any accepted code that is not a single-bit Gray step from the previous
// one, reports the count direction, and keeps a saturating illegal-step count.
module gray_decode_monitor #(
  parameter int WIDTH = 4,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_gray,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_bin,
  output logic             out_step_err,
  output logic             out_dir,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [WIDTH-1:0] prev_gray;
  logic             have_prev;
  logic [WIDTH-1:0] in_bin;
  logic [WIDTH-1:0] prev_bin;
  logic [WIDTH-1:0] diff;
  logic             accept;
  logic             first_code;
  logic             one_bit_step;
  logic             step_up;
  logic             step_err;
  logic             step_dir;

  // Each binary bit is the XOR of all Gray bits at or above it; a reduction per
  // bit avoids a bit-to-bit dependency chain inside one vector.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_decode
      assign in_bin[gi]   = ^in_gray[WIDTH-1:gi];
      assign prev_bin[gi] = ^prev_gray[WIDTH-1:gi];
    end
  endgenerate

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A clear in the accept cycle makes the incoming code a fresh first code.
  assign first_code   = !have_prev || clr;
  assign diff         = in_gray ^ prev_gray;
  assign one_bit_step = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
  // Both sides are WIDTH bits wide, so the +1 wraps from the maximum code to 0.
  assign step_up      = (in_bin == prev_bin + WIDTH'(1));
  assign step_err     = !first_code && !one_bit_step;
  assign step_dir     = !first_code && one_bit_step && step_up;

  // Output register: load on accept, drop valid once the result is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_bin      <= '0;
      out_step_err <= 1'b0;
      out_dir      <= 1'b0;
    end else if (accept) begin
      out_valid    <= 1'b1;
      out_bin      <= in_bin;
      out_step_err <= step_err;
      out_dir      <= step_dir;
    end else if (out_valid && out_ready) begin
      out_valid    <= 1'b0;
    end
  end

  // Step history: follows accepted codes only; clear forgets the history.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_gray <= '0;
      have_prev <= 1'b0;
    end else if (accept) begin
      prev_gray <= in_gray;
      have_prev <= 1'b1;
    end else if (clr) begin
      have_prev <= 1'b0;
    end
  end

  // Illegal-step counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_count <= '0;
    end else if (accept && step_err && (err_count != ERR_MAX)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_gray_decode_monitor.sv
// Self-checking bench for gray_decode_monitor: a table of directed vectors,
// hand-written multi-cycle sequences and a randomized run, all compared against
// a behavioural model. A second instance with a 2-bit counter covers saturation.
module tb_gray_decode_monitor;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, out_ready;
  logic [3:0] in_gray;
  logic       in_ready, out_valid, out_step_err, out_dir;
  logic [3:0] out_bin;
  logic [7:0] err_count;
  logic       in_ready2, out_valid2, out_step_err2, out_dir2;
  logic [3:0] out_bin2;
  logic [1:0] err_count2;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  int m_valid, m_bin, m_err, m_dir, m_cnt8, m_cnt2, m_have, m_prev;

  typedef struct {
    int rst, clr, vld, ordy, gray;
    int e_valid, e_bin, e_err, e_dir, e_cnt;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  gray_decode_monitor #(.WIDTH(4), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_gray(in_gray), .clr(clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_bin(out_bin), .out_step_err(out_step_err), .out_dir(out_dir),
    .err_count(err_count)
  );

  gray_decode_monitor #(.WIDTH(4), .ERR_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
    .in_gray(in_gray), .clr(clr), .out_valid(out_valid2), .out_ready(out_ready),
    .out_bin(out_bin2), .out_step_err(out_step_err2), .out_dir(out_dir2),
    .err_count(err_count2)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Binary value whose Gray code is g, found by search rather than XOR chains.
  function automatic int bin_of(input int g);
    for (int b = 0; b < 16; b++) if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & 15;
  endfunction

  // One clock cycle: drive, check in_ready, advance model, compare outputs.
  task automatic cycle(input int r, input int c, input int v, input int o, input int g);
    int exp_rdy, acc, first, err, b, pb;
    rst = r[0]; clr = c[0]; in_valid = v[0]; out_ready = o[0]; in_gray = g[3:0];
    #1;
    exp_rdy = (!m_valid || o) ? 1 : 0;
    if (!r) begin
      check("in_ready", int'(in_ready), exp_rdy);
      check("in_ready2", int'(in_ready2), exp_rdy);
    end
    acc = v && exp_rdy;
    if (r) begin
      m_valid = 0; m_bin = 0; m_err = 0; m_dir = 0;
      m_cnt8 = 0; m_cnt2 = 0; m_have = 0; m_prev = 0;
    end else begin
      first = (!m_have || c);
      if (c) begin m_cnt8 = 0; m_cnt2 = 0; m_have = 0; end
      if (acc) begin
        b  = bin_of(g);
        pb = bin_of(m_prev);
        err = first ? 0 : ($countones(g ^ m_prev) != 1);
        m_valid = 1;
        m_bin   = b;
        m_err   = err;
        m_dir   = (first || err) ? 0 : (b == (pb + 1) % 16);
        if (err) begin
          if (m_cnt8 < 255) m_cnt8++;
          if (m_cnt2 < 3) m_cnt2++;
        end
        m_prev = g;
        m_have = 1;
      end else if (m_valid && o) begin
        m_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    check("out_valid", int'(out_valid), m_valid);
    check("out_bin", int'(out_bin), m_bin);
    check("out_step_err", int'(out_step_err), m_err);
    if (!m_err) check("out_dir", int'(out_dir), m_dir);
    check("err_count", int'(err_count), m_cnt8);
    check("out_valid2", int'(out_valid2), m_valid);
    check("err_count2", int'(err_count2), m_cnt2);
    if (acc && !r)
      $display("txn gray=%b bin=%0d err=%0d dir=%0d cnt=%0d cnt2=%0d clr=%0d",
               g[3:0], out_bin, out_step_err, out_dir, err_count, err_count2, c);
  endtask

  task automatic add(input int r, input int c, input int v, input int o, input int g,
                     input int ev, input int eb, input int ee, input int ed, input int ec);
    vec_t t;
    t.rst = r; t.clr = c; t.vld = v; t.ordy = o; t.gray = g;
    t.e_valid = ev; t.e_bin = eb; t.e_err = ee; t.e_dir = ed; t.e_cnt = ec;
    vecs.push_back(t);
  endtask

  initial begin
    int r, nb;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_gray = 4'd0;
    m_valid = 0; m_bin = 0; m_err = 0; m_dir = 0;
    m_cnt8 = 0; m_cnt2 = 0; m_have = 0; m_prev = 0;

    // Reset state
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 1, 1, 5);

    // Count up through all 16 codes under continuous flow
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, 1, 1, gray_of(i));
      check("up_bin", int'(out_bin), i);
      check("up_dir", int'(out_dir), (i == 0) ? 0 : 1);
    end
    cycle(0, 0, 0, 1, 0);

    // Directed table: wrap both ways, then jump and repeat after a clear
    cycle(1, 0, 0, 1, 0);
    add(0, 0, 1, 1, 4'b1000, 1, 15, 0, 0, 0);
    add(0, 0, 1, 1, 4'b0000, 1, 0,  0, 1, 0);
    add(0, 0, 1, 1, 4'b1000, 1, 15, 0, 0, 0);
    add(0, 1, 1, 1, 4'b0000, 1, 0,  0, 0, 0);
    add(0, 0, 1, 1, 4'b0011, 1, 2,  1, 0, 1);
    add(0, 0, 1, 1, 4'b0011, 1, 2,  1, 0, 2);
    add(0, 0, 0, 1, 4'b0000, 0, 2,  1, 0, 2);
    foreach (vecs[k]) begin
      cycle(vecs[k].rst, vecs[k].clr, vecs[k].vld, vecs[k].ordy, vecs[k].gray);
      check("tbl_valid", int'(out_valid), vecs[k].e_valid);
      check("tbl_bin", int'(out_bin), vecs[k].e_bin);
      check("tbl_err", int'(out_step_err), vecs[k].e_err);
      if (!vecs[k].e_err) check("tbl_dir", int'(out_dir), vecs[k].e_dir);
      check("tbl_cnt", int'(err_count), vecs[k].e_cnt);
    end

    // Backpressure: stall with a code waiting, then release
    cycle(0, 1, 1, 0, gray_of(4));
    cycle(0, 0, 1, 0, gray_of(5));
    check("bp_ready_low", int'(in_ready), 0);
    cycle(0, 0, 1, 0, gray_of(5));
    check("bp_bin_hold", int'(out_bin), 4);
    cycle(0, 0, 1, 1, gray_of(5));
    check("bp_release_bin", int'(out_bin), 5);
    check("bp_release_dir", int'(out_dir), 1);
    cycle(0, 0, 0, 1, 0);

    // Saturation: fresh code, six repeats, clear, then a clean first code
    cycle(0, 1, 1, 1, gray_of(9));
    for (int i = 0; i < 6; i++) cycle(0, 0, 1, 1, gray_of(9));
    check("sat_cnt2", int'(err_count2), 3);
    check("sat_cnt8", int'(err_count), 6);
    cycle(0, 1, 0, 1, 0);
    check("clr_cnt2", int'(err_count2), 0);
    cycle(0, 0, 1, 1, gray_of(3));
    check("clr_first_err", int'(out_step_err2), 0);

    // Reset during a stalled result
    cycle(0, 0, 1, 0, gray_of(12));
    cycle(0, 0, 1, 0, gray_of(0));
    cycle(1, 0, 1, 0, gray_of(0));
    check("rst_valid", int'(out_valid), 0);
    check("rst_ready", int'(in_ready), 1);
    cycle(0, 0, 1, 1, gray_of(0));
    check("rst_first_err", int'(out_step_err), 0);

    // Randomized traffic: mostly legal steps with occasional jumps
    r = 0;
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 9))
        0:       nb = $urandom_range(0, 15);
        1, 2, 3: nb = (r + 15) % 16;
        default: nb = (r + 1) % 16;
      endcase
      if ($urandom_range(0, 3) != 0) r = nb;
      cycle(($urandom_range(0, 99) == 0) ? 1 : 0,
            ($urandom_range(0, 39) == 0) ? 1 : 0,
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            ($urandom_range(0, 3) != 0) ? 1 : 0,
            gray_of(r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gray_decode_monitor.md
Name: gray_decode_monitor

Overview:
Downstream consumer of the 4-bit binary-to-Gray stage. Accepts a stream of Gray codes over a valid/ready handshake and registers the binary equivalent. Checks each code against the previous accepted code for a legal single-bit Gray step and reports the count direction. Keeps a saturating count of illegal steps, so a counter or converter feeding it can be monitored in-system.

Parameters:
WIDTH, 4, width of the Gray input and binary output.
ERR_W, 8, width of the saturating error counter.

Ports:
clk  input  1  rising-edge clock; the single clock domain.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  upstream Gray code valid.
in_ready  output  1  block can accept a code this cycle.
in_gray  input  WIDTH  Gray code from the upstream stage.
clr  input  1  synchronous clear of err_count and the step history.
out_valid  output  1  out_* holds a decoded result.
out_ready  input  1  downstream accepts the result.
out_bin  output  WIDTH  binary decode of the accepted code.
out_step_err  output  1  accepted code is not a legal single-bit step from the previous code.
out_dir  output  1  1 = step up (+1 mod 2^WIDTH); 0 = step down or no history. Meaningful only when out_step_err=0.
err_count  output  ERR_W  number of illegal steps seen; saturating.

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, out_bin=0, out_step_err=0, out_dir=0, err_count=0.
  - History flag have_prev=0, prev_gray=0.
  - rst overrides every other input in the same cycle.
- in_ready = !out_valid || out_ready. This is combinational, giving a one-deep pipeline with no bubble under continuous flow.
- Accept occurs when in_valid && in_ready.
- On accept, with one-cycle latency:
  - out_valid<=1.
  - out_bin<=gray2bin(in_gray), where bin[WIDTH-1]=g[WIDTH-1] and bin[i]=bin[i+1]^g[i].
  - prev_gray<=in_gray, have_prev<=1.
- Step check, evaluated at accept:
  - have_prev=0: out_step_err<=0, out_dir<=0. The first code is always legal.
  - have_prev=1: out_step_err<=(popcount(in_gray^prev_gray)!=1). A repeated code (popcount 0) is an error.
  - For a legal step, out_dir<=1 when gray2bin(in_gray)==gray2bin(prev_gray)+1 mod 2^WIDTH, else 0.
  - Wrap-around is legal: the maximum code (binary 2^WIDTH-1) followed by 0 is an up step, and 0 followed by the maximum code is a down step.
- err_count increments by 1 on each accept with a step error and holds at 2^ERR_W-1. It never wraps.
- Output handshake:
  - out_valid && out_ready with no new accept: out_valid<=0 next cycle.
  - Output fields hold their values while out_valid=1 && out_ready=0.
  - in_ready=0 in that state, and in_gray is ignored.
- clr=1:
  - err_count<=0, have_prev<=0.
  - An accept in the same cycle is still decoded, but treated as first-code (no error, dir=0); its code becomes prev_gray.
  - clr does not affect out_valid or the data held in the output register.
- prev_gray and have_prev update only on accept, never while stalled.

Test Plan:
1. Reset, then stream in_gray=i^(i>>1) for i=0..15 with out_ready=1 and in_valid held high -> out_bin=0..15 on consecutive cycles starting 1 cycle after the first accept; out_step_err=0 throughout; out_dir=0 for the first code, 1 thereafter; err_count=0.
2. Wrap: 4'b1000 then 4'b0000 -> out_bin 15 then 0, out_step_err=0, out_dir=1. Then 4'b0000 followed by 4'b1000 -> out_dir=0, no error.
3. Illegal jump and repeat: 0000, 0011, 0011 -> second result out_step_err=1 (out_bin=2), third out_step_err=1 (repeat), err_count=2.
4. Backpressure: out_ready=0 while in_valid=1 -> in_ready=0 from the cycle after the first accept; out_bin stays stable. Release out_ready -> the next code is accepted that same cycle, with no lost or duplicated results.
5. Saturation with ERR_W=2: 6 repeated codes -> err_count reaches 3 and holds; clr=1 -> err_count=0, and the next accepted code reports no error.
6. rst asserted mid-stream while out_valid=1 and out_ready=0 -> next cycle out_valid=0, err_count=0, in_ready=1; the first code after reset reports no error.
